// File: rtl/pipelined_ks_adder.sv
// pipelined_ks_adder
//   Add/subtract unit built on a fully pipelined Kogge-Stone carry network.
//   One operand set can be accepted per cycle.
//   A result appears LEVELS+1 cycles after the edge that accepted its operands.
//   A valid/ready handshake on the output side stalls the whole pipe in place.
//
// Parameters
//   WIDTH     operand width, power of two from 4 to 64
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  operand set (a, b, cin, op_sub) is valid
//   in_ready  the pipe can take an operand set this cycle
//   a, b      operands
//   cin       carry-in (add) / borrow-in (subtract)
//   op_sub    0 = a + b + cin, 1 = a - b - borrow (a + ~b + ~cin)
//   out_valid result outputs hold a valid result
//   out_ready consumer takes the result this cycle
//   sum       WIDTH-bit result
//   cout      carry out of the MSB (for subtract: 1 = no borrow)
//   ovf       signed two's-complement overflow
//   zero      sum is all zeros
module pipelined_ks_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);

  // One prefix combine step for a whole level.
  // Positions below the span already cover everything down to position 0.
  // Those positions pass through unchanged.
  function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g,
                                            input logic [WIDTH-1:0] p,
                                            input int span);
    logic [WIDTH-1:0] r;
    r = g;
    for (int j = span; j < WIDTH; j++) begin
      r[j] = g[j] | (p[j] & g[j-span]);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p,
                                            input int span);
    logic [WIDTH-1:0] r;
    r = p;
    for (int j = span; j < WIDTH; j++) begin
      r[j] = p[j] & p[j-span];
    end
    return r;
  endfunction

  logic              stall;
  logic              en;
  logic [LEVELS+1:0] vld_p;

  assign stall     = vld_p[LEVELS+1] & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = vld_p[LEVELS+1];

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic             cin_eff;

  always_comb begin
    b_eff   = op_sub ? ~b : b;
    cin_eff = op_sub ? ~cin : cin;
    g_in    = a & b_eff;
    p_in    = a ^ b_eff;
  end

  // Group generate/propagate arrays.
  // Position 0 is the effective carry-in, a pure generate with p = 0.
  // Position j (j >= 1) is operand bit j-1.
  // After level k, position j covers positions j down to j-2^k+1.
  // So after LEVELS levels, grp_g_p[LEVELS][i] is the carry into bit i.
  logic [WIDTH-1:0] grp_g_p [0:LEVELS];
  logic [WIDTH-1:0] grp_p_p [0:LEVELS];
  // Per-bit propagate and the MSB generate, carried along for the final sum and cout.
  logic [WIDTH-1:0] bit_p_p [0:LEVELS];
  logic [LEVELS:0]  msb_g_p;

  // ---- stage 0: operand register ---- / ---- stages 1..LEVELS: prefix levels ----
  always_ff @(posedge clk) begin
    if (en) begin
      grp_g_p[0] <= {g_in[WIDTH-2:0], cin_eff};
      grp_p_p[0] <= {p_in[WIDTH-2:0], 1'b0};
      bit_p_p[0] <= p_in;
      msb_g_p[0] <= g_in[WIDTH-1];
      for (int k = 1; k <= LEVELS; k++) begin
        grp_g_p[k] <= ks_g(grp_g_p[k-1], grp_p_p[k-1], 1 << (k-1));
        grp_p_p[k] <= ks_p(grp_p_p[k-1], 1 << (k-1));
        bit_p_p[k] <= bit_p_p[k-1];
        msb_g_p[k] <= msb_g_p[k-1];
      end
    end
  end

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_nxt;
  logic             c_msb;
  logic             cout_nxt;

  // The cout merge uses the carry into the MSB plus that bit's own g/p.
  // It is a single AND-OR term, not a ripple.
  always_comb begin
    carry    = grp_g_p[LEVELS];
    sum_nxt  = bit_p_p[LEVELS] ^ carry;
    c_msb    = carry[WIDTH-1];
    cout_nxt = msb_g_p[LEVELS] | (bit_p_p[LEVELS][WIDTH-1] & c_msb);
  end

  logic [WIDTH-1:0] sum_pout;
  logic             cout_pout;
  logic             ovf_pout;
  logic             zero_pout;

  // ---- stage LEVELS+1: output register; valid chain ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p     <= '0;
      sum_pout  <= '0;
      cout_pout <= 1'b0;
      ovf_pout  <= 1'b0;
      zero_pout <= 1'b0;
    end else if (en) begin
      vld_p     <= {vld_p[LEVELS:0], in_valid};
      sum_pout  <= sum_nxt;
      cout_pout <= cout_nxt;
      ovf_pout  <= c_msb ^ cout_nxt;
      zero_pout <= ~|sum_nxt;
    end
  end

  assign sum  = sum_pout;
  assign cout = cout_pout;
  assign ovf  = ovf_pout;
  assign zero = zero_pout;

endmodule

// File: tb/tb_pipelined_ks_adder.sv
module tb_pipelined_ks_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a_d;
  logic [63:0] b_d;
  logic        cin_d;
  logic        sub_d;
  int          sel;

  int n_vec;
  int n_err;
  int rx;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic iv4, iv8, iv32;
  logic ir4, ir8, ir32;
  logic ov4, ov8, ov32;
  logic [3:0]  s4;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic co4, co8, co32, of4, of8, of32, z4, z8, z32;

  assign iv4  = in_valid && (sel == 4);
  assign iv8  = in_valid && (sel == 8);
  assign iv32 = in_valid && (sel == 32);

  pipelined_ks_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a_d[3:0]), .b(b_d[3:0]), .cin(cin_d), .op_sub(sub_d),
    .out_valid(ov4), .out_ready(out_ready),
    .sum(s4), .cout(co4), .ovf(of4), .zero(z4));

  pipelined_ks_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a_d[7:0]), .b(b_d[7:0]), .cin(cin_d), .op_sub(sub_d),
    .out_valid(ov8), .out_ready(out_ready),
    .sum(s8), .cout(co8), .ovf(of8), .zero(z8));

  pipelined_ks_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .a(a_d[31:0]), .b(b_d[31:0]), .cin(cin_d), .op_sub(sub_d),
    .out_valid(ov32), .out_ready(out_ready),
    .sum(s32), .cout(co32), .ovf(of32), .zero(z32));

  logic        obs_valid, obs_ir, obs_cout, obs_ovf, obs_zero;
  logic [63:0] obs_sum;

  always_comb begin
    obs_valid = ov8;
    obs_ir    = ir8;
    obs_sum   = {56'd0, s8};
    obs_cout  = co8;
    obs_ovf   = of8;
    obs_zero  = z8;
    case (sel)
      4: begin
        obs_valid = ov4;
        obs_ir    = ir4;
        obs_sum   = {60'd0, s4};
        obs_cout  = co4;
        obs_ovf   = of4;
        obs_zero  = z4;
      end
      32: begin
        obs_valid = ov32;
        obs_ir    = ir32;
        obs_sum   = {32'd0, s32};
        obs_cout  = co32;
        obs_ovf   = of32;
        obs_zero  = z32;
      end
      default: ;
    endcase
  end

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic res_t model(input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci, input logic sub, input int w);
    logic [63:0] mask, am, be;
    logic [64:0] full;
    logic        ce;
    res_t        r;
    mask   = (64'd1 << w) - 64'd1;
    am     = av & mask;
    be     = sub ? (~bv & mask) : (bv & mask);
    ce     = sub ? ~ci : ci;
    full   = {1'b0, am} + {1'b0, be} + {64'd0, ce};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (am[w-1] == be[w-1]) && (r.sum[w-1] != am[w-1]);
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  task automatic drive(input logic iv, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sub, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a_d       = av;
    b_d       = bv;
    cin_d     = ci;
    sub_d     = sub;
    out_ready = ordy;
    #1;
  endtask

  // One cycle of scoreboard-checked traffic on the selected instance.
  task automatic sb_cycle(input logic iv, input logic [63:0] av, input logic [63:0] bv,
                          input logic ci, input logic sub, input logic ordy,
                          output logic acc);
    res_t e;
    drive(iv, av, bv, ci, sub, ordy);
    acc = iv && obs_ir;
    n_vec++;
    if (obs_ir !== !(obs_valid && !ordy)) begin
      n_err++;
      $display("FAIL in_ready w%0d: got %b, want %b", sel, obs_ir, !(obs_valid && !ordy));
    end
    if (obs_valid === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result w%0d: got sum=%0h, want no valid output", sel, obs_sum);
      end else begin
        e = q[0];
        if (obs_sum !== e.sum || obs_cout !== e.cout || obs_ovf !== e.ovf || obs_zero !== e.zero) begin
          n_err++;
          $display("FAIL result w%0d: got sum=%0h cout=%b ovf=%b zero=%b, want sum=%0h cout=%b ovf=%b zero=%b",
                   sel, obs_sum, obs_cout, obs_ovf, obs_zero, e.sum, e.cout, e.ovf, e.zero);
        end
        if (ordy) begin
          void'(q.pop_front());
          rx++;
        end
      end
    end
    if (acc) q.push_back(model(av, bv, ci, sub, sel));
  endtask

  task automatic drain_pipe();
    logic acc;
    int   cnt;
    cnt = 0;
    while (q.size() > 0 && cnt < 60) begin
      sb_cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
      cnt++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain w%0d: got %0d results still pending, want 0", sel, q.size());
    end
    for (int i = 0; i < 6; i++) sb_cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Single operand set on the 8-bit instance with fixed expected values.
  task automatic run_single(input string name, input logic [63:0] av, input logic [63:0] bv,
                            input logic ci, input logic sub, input logic [7:0] es,
                            input logic ec, input logic eo, input logic ez);
    int lat;
    sel = 8;
    drive(1'b1, av, bv, ci, sub, 1'b1);
    @(posedge clk);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    lat = 0;
    while (obs_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
    n_vec++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, want 4", name, lat);
    end
    n_vec++;
    if (obs_sum[7:0] !== es) begin
      n_err++;
      $display("FAIL %s sum: got %h, want %h", name, obs_sum[7:0], es);
    end
    n_vec++;
    if (obs_cout !== ec || obs_ovf !== eo || obs_zero !== ez) begin
      n_err++;
      $display("FAIL %s flags: got cout=%b ovf=%b zero=%b, want cout=%b ovf=%b zero=%b",
               name, obs_cout, obs_ovf, obs_zero, ec, eo, ez);
    end
  endtask

  task automatic test_reset();
    sel = 8;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    a_d = '0; b_d = '0; cin_d = 1'b0; sub_d = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (obs_valid !== 1'b0 || ov4 !== 1'b0 || ov32 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b/%b/%b, want 0/0/0", ov4, obs_valid, ov32);
    end
    n_vec++;
    if (obs_sum !== 64'd0 || obs_cout !== 1'b0 || obs_ovf !== 1'b0 || obs_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got sum=%0h cout=%b ovf=%b zero=%b, want all 0",
               obs_sum, obs_cout, obs_ovf, obs_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs_ir !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, want 1", obs_ir);
    end
  endtask

  task automatic test_directed();
    run_single("add_ff_01", 64'hFF, 64'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_single("add_7f_01", 64'h7F, 64'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_single("sub_03_05", 64'h03, 64'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_single("sub_05_03", 64'h05, 64'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] av [10];
    logic [63:0] bv [10];
    logic        cv [10];
    logic        sv [10];
    res_t        ev [10];
    logic        vexp;
    sel = 8;
    for (int i = 0; i < 10; i++) begin
      av[i] = 64'($urandom_range(0, 255));
      bv[i] = 64'($urandom_range(0, 255));
      cv[i] = 1'($urandom_range(0, 1));
      sv[i] = 1'($urandom_range(0, 1));
      ev[i] = model(av[i], bv[i], cv[i], sv[i], 8);
    end
    for (int c = 0; c < 18; c++) begin
      if (c < 10) drive(1'b1, av[c], bv[c], cv[c], sv[c], 1'b1);
      else        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      vexp = (c >= 5 && c < 15);
      n_vec++;
      if (obs_valid !== vexp) begin
        n_err++;
        $display("FAIL b2b_valid cycle %0d: got %b, want %b", c, obs_valid, vexp);
      end
      if (vexp) begin
        n_vec++;
        if (obs_sum !== ev[c-5].sum || obs_cout !== ev[c-5].cout ||
            obs_ovf !== ev[c-5].ovf || obs_zero !== ev[c-5].zero) begin
          n_err++;
          $display("FAIL b2b_result %0d: got sum=%0h cout=%b ovf=%b zero=%b, want sum=%0h cout=%b ovf=%b zero=%b",
                   c - 5, obs_sum, obs_cout, obs_ovf, obs_zero,
                   ev[c-5].sum, ev[c-5].cout, ev[c-5].ovf, ev[c-5].zero);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] av [8];
    logic [63:0] bv [8];
    logic        cv [8];
    logic        sv [8];
    logic [63:0] held;
    logic        acc, ordy, exp_stall;
    int          idx, j;
    sel = 8;
    q.delete();
    rx = 0;
    idx = 0;
    held = '0;
    for (int i = 0; i < 8; i++) begin
      av[i] = 64'($urandom_range(0, 255));
      bv[i] = 64'($urandom_range(0, 255));
      cv[i] = 1'($urandom_range(0, 1));
      sv[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 30; c++) begin
      exp_stall = (c >= 7 && c <= 9);
      ordy = !exp_stall;
      j = (idx < 8) ? idx : 7;
      sb_cycle(idx < 8, av[j], bv[j], cv[j], sv[j], ordy, acc);
      if (acc) idx++;
      n_vec++;
      if (obs_ir !== !exp_stall) begin
        n_err++;
        $display("FAIL stall_in_ready cycle %0d: got %b, want %b", c, obs_ir, !exp_stall);
      end
      if (exp_stall) begin
        n_vec++;
        if (obs_valid !== 1'b1) begin
          n_err++;
          $display("FAIL stall_valid cycle %0d: got %b, want 1", c, obs_valid);
        end
        if (c == 7) begin
          held = obs_sum;
        end else begin
          n_vec++;
          if (obs_sum !== held) begin
            n_err++;
            $display("FAIL stall_hold cycle %0d: got %0h, want %0h", c, obs_sum, held);
          end
        end
      end
    end
    drain_pipe();
    n_vec++;
    if (rx != 8 || idx != 8) begin
      n_err++;
      $display("FAIL stall_count: got %0d results from %0d accepted, want 8 from 8", rx, idx);
    end
  endtask

  task automatic test_reset_midflight();
    int w;
    sel = 8;
    q.delete();
    for (int c = 0; c < 3; c++)
      drive(1'b1, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    w = 0;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    while (obs_valid !== 1'b1 && w < 10) begin
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      w++;
    end
    n_vec++;
    if (obs_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_setup: got out_valid=%b, want 1 before reset", obs_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs_valid !== 1'b0 || obs_sum !== 64'd0 || obs_cout !== 1'b0 ||
        obs_ovf !== 1'b0 || obs_zero !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got valid=%b sum=%0h cout=%b ovf=%b zero=%b, want all 0",
               obs_valid, obs_sum, obs_cout, obs_ovf, obs_zero);
    end
    drive(1'b1, 64'h55, 64'h11, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'h66, 64'h22, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (obs_ir !== 1'b1) begin
      n_err++;
      $display("FAIL rst_release_in_ready: got %b, want 1", obs_ir);
    end
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (obs_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stale cycle %0d: got out_valid=%b sum=%0h, want 0", c, obs_valid, obs_sum);
      end
    end
    run_single("post_rst_10_20", 64'h10, 64'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int w, input int n);
    logic acc;
    sel = w;
    q.delete();
    for (int c = 0; c < n; c++) begin
      sb_cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0, acc);
    end
    drain_pipe();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rx    = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random(4, 300);
    test_random(32, 300);
    test_random(8, 200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
